// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;
  typedef enum logic [1:0] {NONE, PORT_I, PORT_D} arb_port_t;

  localparam logic [2:0] FETCH_SIZE = 3'b010;

endpackage

// File: rtl/core_bus_arbiter_pick.sv
// Combinational winner select between fetch and data requesters.
// CORE_BUS_ARB_RR_EN switches ties from fixed D priority to round-robin.
module arb_pick
  import bus_arb_pkg::*;
(
  input  logic      i_req,
  input  logic      d_req,
  input  arb_port_t mask,
  input  logic      last,
  output arb_port_t winner
);

  logic iCand, dCand;

  // The masked port is the one completing this cycle; its valid still shows the old request.
  assign iCand = i_req && (mask != PORT_I);
  assign dCand = d_req && (mask != PORT_D);

`ifdef CORE_BUS_ARB_RR_EN
  // last = 1 means D held the most recent grant, so I wins the next tie.
  always_comb begin
    winner = NONE;
    if (iCand && dCand) winner = last ? PORT_I : PORT_D;
    else if (dCand)     winner = PORT_D;
    else if (iCand)     winner = PORT_I;
  end
`else
  logic unusedLast;
  assign unusedLast = last;

  always_comb begin
    winner = NONE;
    if (dCand)      winner = PORT_D;
    else if (iCand) winner = PORT_I;
  end
`endif

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares one memory port between fetch (I) and data (D) requesters, one transaction in flight.
// Define CORE_BUS_ARB_RR_EN for round-robin arbitration instead of fixed D-over-I priority.
module core_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_valid,
  input  logic [AW-1:0]   i_addr,
  output logic            i_addr_ok,
  output logic            i_data_ok,
  output logic [DW-1:0]   i_data,
  input  logic            d_valid,
  input  logic [AW-1:0]   d_addr,
  input  logic [2:0]      d_size,
  input  logic [DW/8-1:0] d_strobe,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_addr_ok,
  output logic            d_data_ok,
  output logic [DW-1:0]   d_data,
  output logic            m_valid,
  output logic [AW-1:0]   m_addr,
  output logic [2:0]      m_size,
  output logic [DW/8-1:0] m_strobe,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_addr_ok,
  input  logic            m_data_ok,
  input  logic [DW-1:0]   m_data
);

  arb_state_t state;
  arb_port_t  grant, winner, mask;
  logic       lastD, addrAck, complete, pickNow;

  assign addrAck  = (state == REQ) && m_addr_ok;
  assign complete = (addrAck && m_data_ok) || ((state == WAIT) && m_data_ok);
  assign mask     = complete ? grant : NONE;
  assign pickNow  = (state == IDLE) || complete;

  assign i_addr_ok = addrAck  && (grant == PORT_I);
  assign d_addr_ok = addrAck  && (grant == PORT_D);
  assign i_data_ok = complete && (grant == PORT_I);
  assign d_data_ok = complete && (grant == PORT_D);
  assign i_data    = m_data;
  assign d_data    = m_data;

  arb_pick uPick (
    .i_req  (i_valid),
    .d_req  (d_valid),
    .mask   (mask),
    .last   (lastD),
    .winner (winner)
  );

`ifdef CORE_BUS_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      lastD <= 1'b0;
    else if (pickNow && (winner != NONE))
      lastD <= (winner == PORT_D);
  end
`else
  assign lastD = 1'b0;
`endif

  // Request fields are captured only at grant; the memory side sees the register alone.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= NONE;
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_size   <= '0;
      m_strobe <= '0;
      m_wdata  <= '0;
    end else if (pickNow) begin
      case (winner)
        PORT_D: begin
          state    <= REQ;
          grant    <= PORT_D;
          m_valid  <= 1'b1;
          m_addr   <= d_addr;
          m_size   <= d_size;
          m_strobe <= d_strobe;
          m_wdata  <= d_wdata;
        end
        PORT_I: begin
          state    <= REQ;
          grant    <= PORT_I;
          m_valid  <= 1'b1;
          m_addr   <= i_addr;
          m_size   <= FETCH_SIZE;
          m_strobe <= '0;
          m_wdata  <= '0;
        end
        default: begin
          state   <= IDLE;
          grant   <= NONE;
          m_valid <= 1'b0;
        end
      endcase
    end else if (addrAck) begin
      state   <= WAIT;
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Randomized scoreboard bench for core_bus_arbiter: transaction-level arbitration model plus monitor.
module tb_core_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, i_addr_ok, i_data_ok;
  logic [31:0] i_addr, i_data;
  logic        d_valid, d_addr_ok, d_data_ok;
  logic [31:0] d_addr, d_wdata, d_data;
  logic [2:0]  d_size;
  logic [3:0]  d_strobe;
  logic        m_valid, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_data;
  logic [2:0]  m_size;
  logic [3:0]  m_strobe;

  core_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_data(d_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_data(m_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } ev_t;

  // Scoreboard: expected memory requests, and expected ok pulses per output
  // (0 i_addr_ok, 1 d_addr_ok, 2 i_data_ok, 3 d_data_ok).
  req_t  reqQ[$];
  ev_t   respQ[4][$];
  string okName[4] = '{"i_addr_ok", "d_addr_ok", "i_data_ok", "d_data_ok"};

  int nTests = 0, nFail = 0, cyc = 0;

  // Model state: port in service (0 none, 1 I, 2 D) and who was granted last.
  int mPort = 0;
  bit mLastD = 0;

  // Requester and memory agent knobs/state.
  bit iActive, dActive, iFix, dFix, memFix, injectBad;
  int iLeft, dLeft, iGap, dGap, gapMax;
  int memPhase, memCnt, addrDly, dataDly;
  logic [31:0] memVal;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pickGap();
    return (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
  endfunction

  task automatic step();
    bit   legit, badNow, iC, dC;
    int   win, dd;
    req_t r;
    ev_t  e;
    @(negedge clk);
    cyc++;
    legit  = 0;
    badNow = 0;
    if (!iActive && iLeft > 0) begin
      if (iGap > 0) iGap--;
      else begin iActive = 1; iLeft--; end
    end
    if (!dActive && dLeft > 0) begin
      if (dGap > 0) dGap--;
      else begin dActive = 1; dLeft--; end
    end
    i_valid = iActive;
    d_valid = dActive;
    // Fields may wander every cycle; only the grant-cycle values should reach memory.
    if (iActive && !iFix) i_addr = $urandom;
    if (dActive && !dFix) begin
      d_addr   = $urandom;
      d_size   = 3'($urandom_range(0, 7));
      d_strobe = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      d_wdata  = $urandom;
    end
    m_addr_ok = 0;
    m_data_ok = 0;
    m_data    = memFix ? memVal : $urandom;
    if (memPhase == 0 && m_valid) begin
      memPhase = 1;
      memCnt   = (addrDly < 0) ? int'($urandom_range(0, 3)) : addrDly;
    end
    if (memPhase == 1) begin
      if (memCnt == 0) begin
        m_addr_ok = 1;
        if (dataDly < 0) dd = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
        else dd = dataDly;
        if (dd == 0) begin m_data_ok = 1; legit = 1; memPhase = 0; end
        else begin memPhase = 2; memCnt = dd - 1; end
      end else begin
        memCnt--;
        if (injectBad) begin m_data_ok = 1; injectBad = 0; badNow = 1; end
      end
    end else if (memPhase == 2) begin
      if (memCnt == 0) begin m_data_ok = 1; legit = 1; memPhase = 0; end
      else memCnt--;
    end
    #1;
    if (badNow) begin
      chk("stray m_data_ok in REQ, i_data_ok", 32'(i_data_ok), 0);
      chk("stray m_data_ok in REQ, d_data_ok", 32'(d_data_ok), 0);
    end
    if (m_addr_ok && mPort != 0) begin
      e.cyc = cyc; e.data = 0;
      respQ[mPort - 1].push_back(e);
    end
    if (legit && mPort != 0) begin
      e.cyc = cyc; e.data = m_data;
      respQ[mPort + 1].push_back(e);
      if (mPort == 1) begin iActive = 0; iGap = pickGap(); end
      else begin dActive = 0; dGap = pickGap(); end
    end
    // Arbitrate when free or when a transaction finishes; the finishing port sits this one out.
    if (mPort == 0 || legit) begin
      iC  = i_valid && !(legit && mPort == 1);
      dC  = d_valid && !(legit && mPort == 2);
      win = 0;
      if (iC && dC) begin
`ifdef CORE_BUS_ARB_RR_EN
        win = mLastD ? 1 : 2;
`else
        win = 2;
`endif
      end else if (dC) win = 2;
      else if (iC) win = 1;
      r.cyc = cyc;
      if (win == 1) begin
        r.addr = i_addr; r.size = 3'b010; r.strobe = 4'h0; r.wdata = 32'h0;
        reqQ.push_back(r);
      end else if (win == 2) begin
        r.addr = d_addr; r.size = d_size; r.strobe = d_strobe; r.wdata = d_wdata;
        reqQ.push_back(r);
      end
      if (win != 0) mLastD = (win == 2);
      mPort = win;
    end
  endtask

  task automatic doReset(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      resetn = 0; i_valid = 0; d_valid = 0; m_addr_ok = 0; m_data_ok = 0;
    end
    mPort = 0; mLastD = 0; memPhase = 0; injectBad = 0;
    iActive = 0; dActive = 0; iLeft = 0; dLeft = 0;
    reqQ.delete();
    for (int k = 0; k < 4; k++) respQ[k].delete();
    @(negedge clk);
    cyc++;
    // Memory strobes are illegal in IDLE and must be ignored; an unreset FSM would route them.
    resetn = 1; m_addr_ok = 1; m_data_ok = 1;
    #1;
    chk("reset m_valid",   32'(m_valid), 0);
    chk("reset m_addr",    m_addr, 0);
    chk("reset m_size",    32'(m_size), 0);
    chk("reset m_strobe",  32'(m_strobe), 0);
    chk("reset m_wdata",   m_wdata, 0);
    chk("reset i_addr_ok", 32'(i_addr_ok), 0);
    chk("reset i_data_ok", 32'(i_data_ok), 0);
    chk("reset d_addr_ok", 32'(d_addr_ok), 0);
    chk("reset d_data_ok", 32'(d_data_ok), 0);
  endtask

  task automatic runUntilIdle(input int bound);
    int n = 0;
    while ((iLeft > 0 || dLeft > 0 || iActive || dActive || mPort != 0 || memPhase != 0) && n < bound) begin
      step();
      n++;
    end
    chk("traffic drained within cycle budget", 32'(n < bound), 1);
    step();
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or an ok pulse.
  bit   reqOpen = 0;
  req_t cur;
  logic monOk, monHit;
  logic [31:0] monData;

  always @(negedge clk) begin
    #2;
    if (resetn !== 1'b1) begin
      reqOpen = 0;
    end else begin
      if (m_valid) begin
        if (!reqOpen) begin
          if (reqQ.size() == 0) chk("m_valid with no grant expected", 32'(m_valid), 0);
          else begin
            cur = reqQ.pop_front();
            reqOpen = 1;
            chk("request latency (cycle of m_valid)", cyc, cur.cyc + 1);
          end
        end
        if (reqOpen) begin
          chk("m_addr",   m_addr, cur.addr);
          chk("m_size",   32'(m_size), 32'(cur.size));
          chk("m_strobe", 32'(m_strobe), 32'(cur.strobe));
          chk("m_wdata",  m_wdata, cur.wdata);
        end
      end else if (reqOpen) begin
        chk("m_valid held until m_addr_ok", 32'(m_valid), 1);
      end
      if (m_addr_ok) reqOpen = 0;
      for (int k = 0; k < 4; k++) begin
        case (k)
          0: monOk = i_addr_ok;
          1: monOk = d_addr_ok;
          2: monOk = i_data_ok;
          default: monOk = d_data_ok;
        endcase
        monData = (k == 2) ? i_data : d_data;
        monHit  = (respQ[k].size() > 0) && (respQ[k][0].cyc == cyc);
        if (monOk || monHit) begin
          if (!monHit) chk({okName[k], " unexpected"}, 32'(monOk), 0);
          else begin
            chk(okName[k], 32'(monOk), 1);
            if (k >= 2) chk({okName[k], " data"}, monData, respQ[k][0].data);
            void'(respQ[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 0; i_valid = 0; d_valid = 0; i_addr = 0;
    d_addr = 0; d_size = 0; d_strobe = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_data = 0;
    iFix = 0; dFix = 0; memFix = 0; memVal = 0; injectBad = 0;
    iGap = 0; dGap = 0; gapMax = 0; addrDly = -1; dataDly = -1; memCnt = 0;
    doReset(2);

    // Single fetch, memory answers address and data in the first m_valid cycle.
    iFix = 1; i_addr = 32'hBFC0_0000;
    memFix = 1; memVal = 32'h2408_0001; addrDly = 0; dataDly = 0;
    iGap = 0; iLeft = 1;
    runUntilIdle(50);
    memFix = 0;

    // Both rise together: D first, then I re-arbitrated in D's completion cycle.
    dFix = 1; d_addr = 32'h8000_0010; d_size = 3'b010; d_strobe = 4'hF; d_wdata = 32'hDEAD_BEEF;
    i_addr = 32'h0000_1000; addrDly = -1; dataDly = -1;
    iGap = 0; dGap = 0; iLeft = 1; dLeft = 1;
    runUntilIdle(100);

    // Slow memory while the data requester keeps changing its fields.
    dFix = 0; addrDly = 3; dataDly = 2; dGap = 0; dLeft = 1;
    runUntilIdle(100);

    // Both requesters continuously valid for six transactions.
    iFix = 0; addrDly = -1; dataDly = -1; gapMax = 0;
    iGap = 0; dGap = 0; iLeft = 3; dLeft = 3;
    runUntilIdle(200);

    // Reset while waiting for read data, then a fresh fetch.
    addrDly = 0; dataDly = 6; dGap = 0; dLeft = 1;
    n = 0;
    while (memPhase != 2 && n < 20) begin step(); n++; end
    chk("reached data wait before reset", 32'(n < 20), 1);
    step();
    doReset(1);
    iFix = 1; i_addr = 32'hBFC0_0100; addrDly = -1; dataDly = -1; iGap = 0; iLeft = 1;
    runUntilIdle(50);

    // Stray m_data_ok during REQ before the address is accepted.
    addrDly = 3; dataDly = 1; injectBad = 1; iGap = 0; iLeft = 1;
    runUntilIdle(50);

    // Randomized mixed traffic.
    iFix = 0; dFix = 0; addrDly = -1; dataDly = -1; gapMax = 4;
    iGap = 0; dGap = 0; iLeft = 150; dLeft = 150;
    runUntilIdle(5000);

    chk("unserved memory requests left", reqQ.size(), 0);
    for (int k = 0; k < 4; k++) chk({okName[k], " pulses never seen"}, respQ[k].size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
